// File: rtl/md_unit_if.sv
// ============================================================================
// md_unit_if : operand, control and HI/LO result bundle of the multiply/divide unit
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, md_op, A, B, hi_we, lo_we, input busy, HI, LO);
  modport slave  (input start, md_op, A, B, hi_we, lo_we, output busy, HI, LO);
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit  : EX-stage multiply/divide unit holding HI/LO (mult/multu/div/divu,
//            mthi/mtlo). Optional macro MD_CANCEL_EN adds a flush 'cancel' port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
`ifdef MD_CANCEL_EN
  input  logic      cancel,
`endif
  md_unit_if.slave  md
);

  localparam int c_MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CW   = $clog2(c_MAXN + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [63:0]       r_shadow;
  logic              r_wr_ok;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic              w_cancel;
  logic              w_launch;
  logic              w_retire;
  logic              w_mtx;

`ifdef MD_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Result datapath; division works on magnitudes so the MIN/-1 case falls out naturally
  logic        w_signed;
  logic        w_is_div;
  logic        w_div0;
  logic [31:0] w_a_mag, w_b_mag, w_b_div;
  logic [31:0] w_q_mag, w_r_mag, w_q, w_r;
  logic [63:0] w_ext_a, w_ext_b, w_prod, w_result;

  assign w_signed = ~md.md_op[0];
  assign w_is_div = md.md_op[1];
  assign w_div0   = (md.B == 32'd0);
  assign w_a_mag  = (w_signed & md.A[31]) ? -md.A : md.A;
  assign w_b_mag  = (w_signed & md.B[31]) ? -md.B : md.B;
  assign w_b_div  = w_div0 ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_div;
  assign w_r_mag  = w_a_mag % w_b_div;
  assign w_q      = (w_signed & (md.A[31] ^ md.B[31])) ? -w_q_mag : w_q_mag;
  assign w_r      = (w_signed & md.A[31]) ? -w_r_mag : w_r_mag;
  assign w_ext_a  = {{32{w_signed & md.A[31]}}, md.A};
  assign w_ext_b  = {{32{w_signed & md.B[31]}}, md.B};
  assign w_prod   = w_ext_a * w_ext_b;
  assign w_result = w_is_div ? {w_r, w_q} : w_prod;

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_retire    = 1'b0;
    w_mtx       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md.start && !w_cancel) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (!md.start) begin
          w_mtx = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_CW'(1)) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_wr_ok  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_launch) begin
        r_shadow <= w_result;
        r_wr_ok  <= !(w_is_div && w_div0);
        r_cnt    <= w_is_div ? c_CW'(DIV_CYCLES) : c_CW'(MULT_CYCLES);
      end else if (r_state == ST_BUSY && r_cnt != '0) begin
        // Cancel or retire leaves the counter parked at zero
        r_cnt <= (w_state_nxt == ST_IDLE) ? '0 : r_cnt - c_CW'(1);
      end

      if (w_retire && r_wr_ok) begin
        r_hi <= r_shadow[63:32];
        r_lo <= r_shadow[31:0];
      end else if (w_mtx) begin
        if (md.hi_we) r_hi <= md.A;
        if (md.lo_we) r_lo <= md.A;
      end
    end
  end

  assign md.busy = (r_state == ST_BUSY);
  assign md.HI   = r_hi;
  assign md.LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : directed-vector bench for md_unit (define MD_CANCEL_EN for cancel)
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
`ifdef MD_CANCEL_EN
  logic cancel = 1'b0;
`endif
  int vectors = 0;
  int miscompares = 0;

  md_unit_if ifc ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MD_CANCEL_EN
    .cancel (cancel),
`endif
    .md     (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mtx(input logic hw, input logic lw, input logic [31:0] val);
    ifc.hi_we = hw;
    ifc.lo_we = lw;
    ifc.A     = val;
    tick();
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
  endtask

  // Launch one op, count busy cycles, confirm HI/LO hold until completion
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] pre_hi,
                        input logic [31:0] pre_lo, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic we, input int inj);
    int cnt;
    logic stable;
    ifc.start = 1'b1;
    ifc.md_op = op;
    ifc.A     = a;
    ifc.B     = b;
    ifc.hi_we = we;
    ifc.lo_we = we;
    tick();
    ifc.start = 1'b0;
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    ifc.A     = 32'h5A5A_0F0F;
    cnt    = 0;
    stable = 1'b1;
    while (ifc.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (ifc.HI !== pre_hi || ifc.LO !== pre_lo) stable = 1'b0;
      if (cnt == inj) begin
        ifc.start = 1'b1;
        ifc.lo_we = 1'b1;
        ifc.md_op = 2'b11;
        ifc.A     = 32'h0000_0055;
        ifc.B     = 32'd1;
      end else begin
        ifc.start = 1'b0;
        ifc.lo_we = 1'b0;
      end
      tick();
    end
    ifc.start = 1'b0;
    ifc.lo_we = 1'b0;
    chk({tag, " busy_cycles"}, 32'(cnt), 32'(n));
    chk({tag, " hold"}, {31'd0, stable}, 32'd1);
    chk({tag, " HI"}, ifc.HI, ehi);
    chk({tag, " LO"}, ifc.LO, elo);
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.md_op = 2'b00;
    ifc.A     = '0;
    ifc.B     = '0;
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;

    tick();
    tick();
    chk("reset HI", ifc.HI, 32'd0);
    chk("reset LO", ifc.LO, 32'd0);
    chk("reset busy", {31'd0, ifc.busy}, 32'd0);

    // Reset asserted mid-operation
    reset = 1'b1;
    tick();
    mtx(1'b1, 1'b0, 32'h0000_1234);
    chk("mthi pre-reset", ifc.HI, 32'h0000_1234);
    ifc.start = 1'b1; ifc.md_op = 2'b00; ifc.A = 32'd4; ifc.B = 32'd4;
    tick();
    ifc.start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst busy", {31'd0, ifc.busy}, 32'd0);
    chk("midrst HI", ifc.HI, 32'd0);
    chk("midrst LO", ifc.LO, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    run_op("mult 2*3", 2'b00, 32'd2, 32'd3, 5, 32'd0, 32'd0, 32'd0, 32'd6, 1'b0, 0);
    run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 5, 32'd0, 32'd6,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFE, 32'h0000_0001,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd0, 32'h8000_0000, 1'b0, 0);

    mtx(1'b1, 1'b0, 32'h0000_0011);
    chk("mthi 11", ifc.HI, 32'h0000_0011);
    mtx(1'b0, 1'b1, 32'h0000_0022);
    chk("mtlo 22", ifc.LO, 32'h0000_0022);
    chk("mtlo keeps HI", ifc.HI, 32'h0000_0011);

    run_op("divu 7/0", 2'b11, 32'd7, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0, 0);

    mtx(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("mthi DEADBEEF", ifc.HI, 32'hDEAD_BEEF);
    chk("mthi keeps LO", ifc.LO, 32'h0000_0022);
    mtx(1'b1, 1'b1, 32'hCAFE_F00D);
    chk("both we HI", ifc.HI, 32'hCAFE_F00D);
    chk("both we LO", ifc.LO, 32'hCAFE_F00D);

    // start together with mthi/mtlo: writes must be dropped
    run_op("start+we", 2'b00, 32'h10, 32'd1, 5, 32'hCAFE_F00D, 32'hCAFE_F00D,
           32'd0, 32'h10, 1'b1, 0);
    // second start plus mtlo injected at busy cycle 2
    run_op("inject", 2'b00, 32'd7, 32'd9, 5, 32'd0, 32'h10, 32'd0, 32'd63, 1'b0, 2);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 10, 32'd0, 32'd63, 32'd2, 32'd14, 1'b0, 0);

`ifdef MD_CANCEL_EN
    begin
      int k;
      ifc.start = 1'b1; ifc.md_op = 2'b10; ifc.A = 32'd50; ifc.B = 32'd3;
      tick();
      ifc.start = 1'b0;
      k = 1;
      while (k < 3 && ifc.busy === 1'b1) begin
        k++;
        tick();
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel busy", {31'd0, ifc.busy}, 32'd0);
      chk("cancel HI", ifc.HI, 32'd2);
      chk("cancel LO", ifc.LO, 32'd14);
      repeat (12) tick();
      chk("cancel late HI", ifc.HI, 32'd2);
      chk("cancel late LO", ifc.LO, 32'd14);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
